mult_seq_ctrl: RTL and testbench



---
 rtl/mult_seq_ctrl_pkg.sv | 26 ++
 rtl/mult_seq_ctrl_if.sv | 29 ++
 rtl/mult_seq_ctrl_pp_mult2.sv | 19 +
 rtl/mult_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential 2-bit-slice multiplier.
//   state_t     : controller FSM states (IDLE / CALC / HOLD)
//   DIGIT_W     : width of one operand digit fed to the partial-product slice
//   PP_W        : width of one partial product (DIGIT_W x DIGIT_W)
//   digits_of() : number of digits in an operand of a given width
//   cnt_width() : width of a digit counter, never narrower than one bit
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;
  localparam int PP_W    = 2 * DIGIT_W;

  function automatic int digits_of(input int width);
    return width / DIGIT_W;
  endfunction

  function automatic int cnt_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle for mult_seq_ctrl.
//   in_valid/in_ready   : operand handshake (a_in, b_in)
//   out_valid/out_ready : result handshake (product)
//   busy                : multiplier is stepping through digit pairs
// master = requesting datapath, slave = the multiplier sequencer.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/mult_seq_ctrl_pp_mult2.sv
// Purely combinational 2-bit x 2-bit unsigned partial-product slice.
//   x, y : 2-bit unsigned digits
//   p    : 4-bit unsigned product x*y, built from two shifted AND rows
module pp_mult2
  import mult_seq_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic [PP_W-1:0]    p
);

  logic [PP_W-1:0] row0;
  logic [PP_W-1:0] row1;

  assign row0 = {2'b00, x & {DIGIT_W{y[0]}}};
  assign row1 = {1'b0, x & {DIGIT_W{y[1]}}, 1'b0};
  assign p    = row0 + row1;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned WIDTH x WIDTH multiplier that reuses a single 2x2
// partial-product slice over every digit pair (i, j) and shift-accumulates
// the results into a 2*WIDTH-bit product.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : slave side of mult_seq_ctrl_if
//          in_valid/in_ready/a_in/b_in   operand handshake
//          out_valid/out_ready/product   result handshake
//          busy                          high while stepping digit pairs
// One product takes DIGITS^2 CALC cycles followed by at least one HOLD cycle.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  mult_seq_ctrl_if.slave bus
);

  localparam int DIGITS = digits_of(WIDTH);
  localparam int CNT_W  = cnt_width(DIGITS);
  localparam int PROD_W = 2 * WIDTH;
  localparam int SH_W   = CNT_W + 2;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]                  a_reg;
  logic [WIDTH-1:0]                  b_reg;
  logic [PROD_W-1:0]                 acc;
  logic [PROD_W-1:0]                 product_reg;
  logic [CNT_W-1:0]                  i_cnt;
  logic [CNT_W-1:0]                  j_cnt;

  logic [DIGITS-1:0][DIGIT_W-1:0]    a_dig;
  logic [DIGITS-1:0][DIGIT_W-1:0]    b_dig;
  logic [PP_W-1:0]                   pp;
  logic [SH_W-1:0]                   shamt;
  logic [PROD_W-1:0]                 term;
  logic [PROD_W-1:0]                 acc_sum;
  logic                              i_last;
  logic                              j_last;

  // Operands viewed as little-endian digit arrays so the counters index
  // digits directly.
  assign a_dig = a_reg;
  assign b_dig = b_reg;

  pp_mult2 u_pp (
    .x (a_dig[i_cnt]),
    .y (b_dig[j_cnt]),
    .p (pp)
  );

  // Digit pair (i, j) has weight 4^(i+j), i.e. a left shift of 2*(i+j).
  assign shamt   = ({2'b00, i_cnt} + {2'b00, j_cnt}) << 1;
  assign term    = PROD_W'(pp) << shamt;
  assign acc_sum = acc + term;

  assign i_last = (i_cnt == CNT_W'(DIGITS - 1));
  assign j_last = (j_cnt == CNT_W'(DIGITS - 1));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid)     state_nxt = CALC;
      CALC: if (i_last && j_last) state_nxt = HOLD;
      HOLD: if (bus.out_ready)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (pure functions of state, so there is no combinational
  // path from the input handshake to the output handshake)
  // ---------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE:    bus.in_ready  = 1'b1;
      CALC:    bus.busy      = 1'b1;
      HOLD:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  assign bus.product = product_reg;

  // ---------------------------------------------------------------------
  // Datapath: operand capture, digit counters, accumulator, result
  // ---------------------------------------------------------------------
  // Reset clears everything, including the product, so an aborted
  // calculation can never leak a partial result. Outside reset the product
  // register only changes on the final CALC step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      i_cnt       <= '0;
      j_cnt       <= '0;
      product_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a_in;
            b_reg <= bus.b_in;
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
          end
        end
        CALC: begin
          acc <= acc_sum;
          // j is the inner digit index; i advances when j wraps.
          if (j_last) begin
            j_cnt <= '0;
            i_cnt <= i_last ? '0 : i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
          if (i_last && j_last) begin
            product_reg <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl (WIDTH = 8).
// A behavioural model tracks what the block must show: after an accepted
// request it stays busy for LAT cycles, then presents a*b until out_ready.
// A compare process checks every cycle; directed scenarios add literal pins.
module tb_mult_seq_ctrl;

  localparam int WIDTH  = 8;
  localparam int LAT    = (WIDTH / 2) * (WIDTH / 2);
  localparam int PROD_W = 2 * WIDTH;

  logic clk;
  logic rst;

  mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                m_left  = 0;     // CALC cycles still to run
  bit                m_valid = 1'b0;
  logic [PROD_W-1:0] m_prod  = '0;
  logic [PROD_W-1:0] m_pend  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left  = 0;
      m_valid = 1'b0;
      m_prod  = '0;
    end else if (m_left == 0 && !m_valid) begin
      if (bus.in_valid) begin
        m_left = LAT;
        m_pend = PROD_W'(bus.a_in) * PROD_W'(bus.b_in);
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        m_prod  = m_pend;
      end
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",  32'(bus.in_ready),  32'(m_left == 0 && !m_valid));
      check("busy",      32'(bus.busy),      32'(m_left > 0));
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("product",   32'(bus.product),   32'(m_prod));
    end
  end

  // ---------------- directed transaction ----------------
  // Accepts one operand pair, measures latency (edges from the accepting
  // edge inclusive up to out_valid), checks the literal product, holds
  // backpressure for 'hold' cycles, and optionally pokes in_valid mid-CALC.
  task automatic do_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [PROD_W-1:0] exp_p, input int hold,
                        input bit inject);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_drop", 32'(bus.in_ready), 32'd0);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      if (inject && n == 5) begin
        bus.in_valid = 1'b1;
        bus.a_in     = 8'h07;
        bus.b_in     = 8'h07;
      end
      if (inject && n == 8) bus.in_valid = 1'b0;
      if (inject && n >= 5 && n < 8) check("in_ready_calc", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(LAT + 1));
    check("product_lit", 32'(bus.product), 32'(exp_p));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_product", 32'(bus.product), 32'(exp_p));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("ready_back", 32'(bus.in_ready), 32'd1);
    check("valid_gone", 32'(bus.out_valid), 32'd0);
    check("product_kept", 32'(bus.product), 32'(exp_p));
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_product",   32'(bus.product),   32'd0);

    do_txn(8'd13, 8'd11, 16'd143,  0, 1'b0);
    do_txn(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0);
    do_txn(8'h00, 8'hA5, 16'h0000, 0, 1'b0);
    do_txn(8'h80, 8'h02, 16'h0100, 5, 1'b0);
    do_txn(8'd3,  8'd3,  16'd9,    0, 1'b1);

    // Reset in the middle of CALC, with in_valid also high during reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = 8'h55;
    bus.b_in     = 8'h33;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_mid", 32'(bus.busy), 32'd1);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_in     = 8'hFF;
    @(negedge clk);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_product",   32'(bus.product),   32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("no_accept_in_rst", 32'(bus.in_ready), 32'd1);
    do_txn(8'd200, 8'd3, 16'd600, 0, 1'b0);

    // Randomized traffic, including occasional resets and corner operands.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       bus.a_in = 8'h00;
        1:       bus.a_in = 8'hFF;
        default: bus.a_in = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       bus.b_in = 8'h00;
        1:       bus.b_in = 8'hFF;
        default: bus.b_in = WIDTH'($urandom);
      endcase
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rst           = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
